regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Shares the single write port of the 16x8 register file (writeAddr/writeData) among NumReq writeback requesters: ALU result, load return, immediate/move.
- Round-robin arbitration with per-requester valid/ready handshake.
- Lock mode lets one requester write back-to-back multi-register sequences.
- Registered write-port outputs; sits between the execute/writeback stage and the register file.

Parameters:
- NumReq, 3, number of write requesters (2..8).
- NumRegs, 16, register-file depth.
- IndexWidth, $clog2(NumRegs), register address width.
- DataWidth, 8, register data width.
- SrcWidth, $clog2(NumReq), width of the source-id output.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NumReq  per-requester write request.
- req_lock  in  NumReq  requester wants to keep the grant after this transfer.
- req_addr  in  NumReq x IndexWidth  target register per requester.
- req_data  in  NumReq x DataWidth  write data per requester.
- req_ready  out  NumReq  one-hot grant; transfer when valid & ready.
- hold  in  1  sequencer stall; blocks all grants.
- wr_en  out  1  register-file write strobe.
- writeAddr  out  IndexWidth  register-file write address.
- writeData  out  DataWidth  register-file write data.
- wr_src  out  SrcWidth  index of requester owning the current write.
- locked  out  1  high while in ST_LOCKED.

Behaviour:
- Reset (async, rst_n=0): wr_en=0, writeAddr=0, writeData=0, wr_src=0, locked=0, state=ST_IDLE, rr pointer ptr=0. req_ready is combinational and is 0 for all requesters while hold=1 or during reset.
- req_ready: combinational from the current state, ptr and req_valid. It never depends on req_addr or req_data.
- ST_IDLE arbitration (hold=0):
  - Winner = first i with req_valid[i], searching ptr, ptr+1, ... and wrapping at NumReq.
  - req_ready[winner]=1; all other ready bits are 0. No valid requesters means no grant.
- Transfer in ST_IDLE:
  - If req_lock[winner]=0: ptr <= (winner+1) mod NumReq.
  - If req_lock[winner]=1: state <= ST_LOCKED, owner <= winner, ptr unchanged.
- ST_LOCKED (hold=0):
  - Only owner is eligible; req_ready[owner]=req_valid[owner]; others 0.
  - Owner transfer with req_lock=0: state <= ST_IDLE, ptr <= (owner+1) mod NumReq.
  - Owner transfer with req_lock=1: stay in ST_LOCKED.
  - Owner req_valid=0: release to ST_IDLE, ptr <= (owner+1) mod NumReq, no grant that cycle.
- Write port, latency 1:
  - On a transfer in cycle N: wr_en=1, writeAddr/writeData = the winner's addr/data, wr_src=winner, all in cycle N+1.
  - No transfer: wr_en <= 0; writeAddr/writeData/wr_src hold their last values.
  - Sustained throughput is one write per cycle.
- hold=1: all ready bits 0, wr_en <= 0, state/ptr/owner frozen. A lock survives hold. Deasserting hold resumes next cycle with no lost state.
- Requester index NumReq-1 wraps ptr to 0.
- Requesters must keep addr/data stable while valid & !ready; the arbiter does not check this.
- Reset mid-lock or mid-write: immediate return to reset values; no partial write is ever issued.

Optional Feature:
- Macro RFARB_R0_DISCARD_EN.
- Defined: transfers with req_addr==0 are accepted normally (ready, ptr/lock update unchanged), but wr_en stays 0 the next cycle. This makes r0 read-as-written-zero at the write side. writeAddr/writeData/wr_src still update.
- Undefined: address 0 is written like any other register.

Decomposition:
- Package rfarb_pkg holds:
  - REG_ADDR_W=4 and REG_DATA_W=8 constants.
  - typedef enum logic {ST_IDLE, ST_LOCKED} rfarb_state_t.
  - typedef struct {addr, data} rf_wr_t.
- Sub-module rr_pick: combinational round-robin picker. Inputs: req vector and ptr. Outputs: one-hot grant and winner index. Instantiated once; all state stays in regfile_wr_arbiter.

Test Plan:
- Reset then req_valid=3'b111, addrs 1/2/3, data 8'hA1/A2/A3, hold=0: grants cycle 0->1->2. wr_en=1 for 3 consecutive cycles starting 1 cycle later, writeAddr=1,2,3, wr_src=0,1,2.
- req1 asserts lock with addrs 4,5,6 while req0 and req2 stay valid: three consecutive writes from src 1, locked=1 throughout. Lock drops on the last transfer; next grant goes to req2 (ptr=2).
- hold=1 for 3 cycles with all requests valid: req_ready=0, wr_en=0. After release, arbitration resumes from the frozen ptr.
- Locked owner drops req_valid: locked=0 the next cycle, no write that cycle, ptr=owner+1.
- rst_n pulsed low while in ST_LOCKED with wr_en=1: wr_en, writeAddr, writeData and locked are 0 immediately. After release, the first grant goes to req0.
- With RFARB_R0_DISCARD_EN defined, req0 writes addr 0 data 8'hFF: ready=1, wr_en=0 the next cycle. Without the macro, wr_en=1, writeAddr=0, writeData=8'hFF.

Source files
------------

// File: rtl/rfarb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// The optional macro RFARB_R0_DISCARD_EN is handled in regfile_wr_arbiter.sv.
package rfarb_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 8;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } rfarb_state_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first asserted request
// starting at ptr and wrapping at NumReq, returning a one-hot grant and
// the index of the winner.
module rr_pick #(
    parameter int NumReq   = 3,
    parameter int SrcWidth = $clog2(NumReq)
) (
    input  logic [NumReq-1:0]   req,
    input  logic [SrcWidth-1:0] ptr,
    output logic [NumReq-1:0]   grant,
    output logic [SrcWidth-1:0] winner
);

    // Scan from ptr upward with wraparound; the first hit wins.
    always_comb begin
        int  idx;
        logic found;
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NumReq; k++) begin
            idx = (int'(ptr) + k) % NumReq;
            if (!found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                winner      = SrcWidth'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NumReq
// writeback requesters, with a lock mode for back-to-back sequences.
// Optional macro RFARB_R0_DISCARD_EN: accepted writes to r0 do not raise wr_en.
module regfile_wr_arbiter
    import rfarb_pkg::*;
#(
    parameter int NumReq     = 3,
    parameter int NumRegs    = 16,
    parameter int IndexWidth = $clog2(NumRegs),
    parameter int DataWidth  = REG_DATA_W,
    parameter int SrcWidth   = $clog2(NumReq)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NumReq-1:0]                   req_valid,
    input  logic [NumReq-1:0]                   req_lock,
    input  logic [NumReq-1:0][IndexWidth-1:0]   req_addr,
    input  logic [NumReq-1:0][DataWidth-1:0]    req_data,
    output logic [NumReq-1:0]                   req_ready,
    input  logic                                hold,
    output logic                                wr_en,
    output logic [IndexWidth-1:0]               writeAddr,
    output logic [DataWidth-1:0]                writeData,
    output logic [SrcWidth-1:0]                 wr_src,
    output logic                                locked
);

    rfarb_state_t        state, next_state;
    logic [SrcWidth-1:0] ptr, next_ptr;
    logic [SrcWidth-1:0] owner, next_owner;
    logic [NumReq-1:0]   eligible;
    logic [NumReq-1:0]   grant;
    logic [SrcWidth-1:0] winner;
    logic                transfer;
    logic                wr_fire;

    function automatic logic [SrcWidth-1:0] wrap_inc(input logic [SrcWidth-1:0] i);
        return (i == SrcWidth'(NumReq - 1)) ? '0 : i + 1'b1;
    endfunction

    // While locked only the owner may compete; otherwise everyone may.
    always_comb begin
        eligible = req_valid;
        if (state == ST_LOCKED) begin
            eligible = req_valid & (NumReq'(1) << owner);
        end
    end

    rr_pick #(
        .NumReq   (NumReq),
        .SrcWidth (SrcWidth)
    ) u_pick (
        .req    (eligible),
        .ptr    (ptr),
        .grant  (grant),
        .winner (winner)
    );

    assign transfer = |(req_valid & req_ready);
    assign locked   = (state == ST_LOCKED);

    // State, pointer and owner registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= next_state;
            ptr   <= next_ptr;
            owner <= next_owner;
        end
    end

    // Next-state logic: lock entry/exit and round-robin pointer advance.
    always_comb begin
        next_state = state;
        next_ptr   = ptr;
        next_owner = owner;
        if (!hold) begin
            unique case (state)
                ST_IDLE: begin
                    if (transfer) begin
                        if (req_lock[winner]) begin
                            next_state = ST_LOCKED;
                            next_owner = winner;
                        end else begin
                            next_ptr = wrap_inc(winner);
                        end
                    end
                end
                ST_LOCKED: begin
                    if (!req_valid[owner] || !req_lock[owner]) begin
                        next_state = ST_IDLE;
                        next_ptr   = wrap_inc(owner);
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Grant outputs: nothing is granted under hold or reset.
    always_comb begin
        req_ready = '0;
        if (!hold && rst_n) begin
            req_ready = grant;
        end
    end

`ifdef RFARB_R0_DISCARD_EN
    assign wr_fire = (req_addr[winner] != '0);
`else
    assign wr_fire = 1'b1;
`endif

    // Registered write port: one cycle after each accepted transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en     <= 1'b0;
            writeAddr <= '0;
            writeData <= '0;
            wr_src    <= '0;
        end else if (transfer) begin
            wr_en     <= wr_fire;
            writeAddr <= req_addr[winner];
            writeData <= req_data[winner];
            wr_src    <= winner;
        end else begin
            wr_en     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed self-checking bench for regfile_wr_arbiter (default parameters).
module tb_regfile_wr_arbiter;

    logic            clk;
    logic            rst_n;
    logic [2:0]      req_valid;
    logic [2:0]      req_lock;
    logic [2:0][3:0] req_addr;
    logic [2:0][7:0] req_data;
    logic [2:0]      req_ready;
    logic            hold;
    logic            wr_en;
    logic [3:0]      writeAddr;
    logic [7:0]      writeData;
    logic [1:0]      wr_src;
    logic            locked;

    int checkCount = 0;
    int passCount  = 0;

    regfile_wr_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .hold      (hold),
        .wr_en     (wr_en),
        .writeAddr (writeAddr),
        .writeData (writeData),
        .wr_src    (wr_src),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] valid, input logic [2:0] lock, input logic h);
        req_valid = valid;
        req_lock  = lock;
        hold      = h;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkWrite(input string tag, input logic en, input logic [3:0] a,
                              input logic [7:0] d, input logic [1:0] s);
        checkOutput({tag, ".wr_en"}, 32'(wr_en), 32'(en));
        checkOutput({tag, ".addr"},  32'(writeAddr), 32'(a));
        checkOutput({tag, ".data"},  32'(writeData), 32'(d));
        checkOutput({tag, ".src"},   32'(wr_src), 32'(s));
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_data  = '0;
        hold      = 1'b0;
        #1;
        checkWrite("reset", 1'b0, 4'd0, 8'h00, 2'd0);
        checkOutput("reset.locked", 32'(locked), 32'd0);
        checkOutput("reset.ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain round robin 0 -> 1 -> 2
        req_addr[0] = 4'd1; req_data[0] = 8'hA1;
        req_addr[1] = 4'd2; req_data[1] = 8'hA2;
        req_addr[2] = 4'd3; req_data[2] = 8'hA3;
        applyStimulus(3'b111, 3'b000, 1'b0);
        checkOutput("rr.ready0", 32'(req_ready), 32'b001);
        tick();
        checkWrite("rr.w0", 1'b1, 4'd1, 8'hA1, 2'd0);
        checkOutput("rr.ready1", 32'(req_ready), 32'b010);
        tick();
        checkWrite("rr.w1", 1'b1, 4'd2, 8'hA2, 2'd1);
        checkOutput("rr.ready2", 32'(req_ready), 32'b100);
        tick();
        checkWrite("rr.w2", 1'b1, 4'd3, 8'hA3, 2'd2);
        checkOutput("rr.wrap", 32'(req_ready), 32'b001);

        // Move ptr to 1 with a lone req0 transfer
        req_addr[0] = 4'd7; req_data[0] = 8'h70;
        applyStimulus(3'b001, 3'b000, 1'b0);
        tick();
        checkWrite("pre.w", 1'b1, 4'd7, 8'h70, 2'd0);

        // Locked sequence from req1
        req_addr[1] = 4'd4; req_data[1] = 8'hB4;
        applyStimulus(3'b111, 3'b010, 1'b0);
        checkOutput("lock.ready", 32'(req_ready), 32'b010);
        checkOutput("lock.pre", 32'(locked), 32'd0);
        tick();
        checkWrite("lock.w4", 1'b1, 4'd4, 8'hB4, 2'd1);
        checkOutput("lock.l1", 32'(locked), 32'd1);
        req_addr[1] = 4'd5; req_data[1] = 8'hB5;
        applyStimulus(3'b111, 3'b010, 1'b0);
        checkOutput("lock.ready5", 32'(req_ready), 32'b010);
        tick();
        checkWrite("lock.w5", 1'b1, 4'd5, 8'hB5, 2'd1);
        checkOutput("lock.l2", 32'(locked), 32'd1);
        req_addr[1] = 4'd6; req_data[1] = 8'hB6;
        applyStimulus(3'b111, 3'b000, 1'b0);
        checkOutput("lock.ready6", 32'(req_ready), 32'b010);
        tick();
        checkWrite("lock.w6", 1'b1, 4'd6, 8'hB6, 2'd1);
        checkOutput("lock.rel", 32'(locked), 32'd0);
        checkOutput("lock.next", 32'(req_ready), 32'b100);

        // Hold freezes everything
        applyStimulus(3'b111, 3'b000, 1'b1);
        checkOutput("hold.ready", 32'(req_ready), 32'b000);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("hold.wr_en", 32'(wr_en), 32'd0);
            checkOutput("hold.readyN", 32'(req_ready), 32'b000);
        end
        applyStimulus(3'b111, 3'b000, 1'b0);
        checkOutput("hold.resume", 32'(req_ready), 32'b100);
        tick();
        checkWrite("hold.w", 1'b1, 4'd3, 8'hA3, 2'd2);

        // Locked owner drops valid
        req_addr[0] = 4'd8; req_data[0] = 8'hC8;
        applyStimulus(3'b111, 3'b001, 1'b0);
        checkOutput("drop.ready", 32'(req_ready), 32'b001);
        tick();
        checkWrite("drop.w", 1'b1, 4'd8, 8'hC8, 2'd0);
        checkOutput("drop.locked", 32'(locked), 32'd1);
        applyStimulus(3'b110, 3'b001, 1'b0);
        checkOutput("drop.noGrant", 32'(req_ready), 32'b000);
        tick();
        checkOutput("drop.unlocked", 32'(locked), 32'd0);
        checkOutput("drop.noWrite", 32'(wr_en), 32'd0);
        checkOutput("drop.ptr", 32'(req_ready), 32'b010);

        // Reset while locked with a write in flight
        req_addr[1] = 4'd9; req_data[1] = 8'hD9;
        applyStimulus(3'b010, 3'b010, 1'b0);
        tick();
        checkWrite("rst.pre", 1'b1, 4'd9, 8'hD9, 2'd1);
        checkOutput("rst.preLock", 32'(locked), 32'd1);
        rst_n = 1'b0;
        #1;
        checkWrite("rst.mid", 1'b0, 4'd0, 8'h00, 2'd0);
        checkOutput("rst.locked", 32'(locked), 32'd0);
        checkOutput("rst.ready", 32'(req_ready), 32'b000);
        applyStimulus(3'b111, 3'b000, 1'b0);
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("rst.first", 32'(req_ready), 32'b001);
        tick();
        checkWrite("rst.w", 1'b1, 4'd8, 8'hC8, 2'd0);

        // Write to r0
        req_addr[0] = 4'd0; req_data[0] = 8'hFF;
        applyStimulus(3'b001, 3'b000, 1'b0);
        checkOutput("r0.ready", 32'(req_ready), 32'b001);
        tick();
`ifdef RFARB_R0_DISCARD_EN
        checkWrite("r0.w", 1'b0, 4'd0, 8'hFF, 2'd0);
`else
        checkWrite("r0.w", 1'b1, 4'd0, 8'hFF, 2'd0);
`endif
        applyStimulus(3'b000, 3'b000, 1'b0);
        tick();
        checkOutput("idle.wr_en", 32'(wr_en), 32'd0);
        checkOutput("idle.ready", 32'(req_ready), 32'b000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
